// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: load/store funct3 encodings,
// the memory-stage FSM states and the MEM/WB pipeline register layout.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu_result;
        logic [31:0] mem_data;
        logic        mem_to_reg;
        logic        reg_write;
        logic [4:0]  rd;
    } memwb_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store lane steering: store replication and byte enables,
// load lane extraction with sign/zero extension, and illegal-access detection.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] load_data_o,
    output logic        bad_o
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        bad_o = 1'b0;
        if (mem_read_i && mem_write_i) begin
            bad_o = 1'b1;
        end else if (mem_read_i) begin
            case (funct3_i)
                F3_B, F3_BU: bad_o = 1'b0;
                F3_H, F3_HU: bad_o = off_i[0];
                F3_W:        bad_o = (off_i != 2'b00);
                default:     bad_o = 1'b1;
            endcase
        end else if (mem_write_i) begin
            case (funct3_i)
                F3_B:    bad_o = 1'b0;
                F3_H:    bad_o = off_i[0];
                F3_W:    bad_o = (off_i != 2'b00);
                default: bad_o = 1'b1;
            endcase
        end
    end

    // Stores replicate the datum into every lane so memory only needs the enables.
    always_comb begin
        wdata_o = store_data_i;
        be_o    = 4'b1111;
        if (mem_write_i) begin
            case (funct3_i)
                F3_B: begin
                    wdata_o = {4{store_data_i[7:0]}};
                    be_o    = 4'b0001 << off_i;
                end
                F3_H: begin
                    wdata_o = {2{store_data_i[15:0]}};
                    be_o    = 4'b0011 << off_i;
                end
                default: begin
                    wdata_o = store_data_i;
                    be_o    = 4'b1111;
                end
            endcase
        end
    end

    assign byte_shift = rdata_i >> {off_i, 3'b000};
    assign half_shift = rdata_i >> {off_i[1], 4'b0000};
    assign ld_byte    = byte_shift[7:0];
    assign ld_half    = half_shift[15:0];

    always_comb begin
        case (funct3_i)
            F3_B:    load_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_data_o = {24'h0, ld_byte};
            F3_H:    load_data_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_data_o = {16'h0, ld_half};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues data-memory requests, stalls upstream while waiting,
// reports misaligned/timeout faults and holds the MEM/WB register.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_mem_to_reg,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_fault,
    output logic        wb_valid,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_mem_data,
    output logic        wb_mem_to_reg,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd
);

    localparam int CW = $clog2(TIMEOUT + 1);

    mem_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    memwb_t      wb_q, wb_d;

    logic        is_mem;
    logic        bad;
    logic        legal;
    logic        timeout;
    logic [31:0] load_data;

    lsu_align u_align (
        .off_i        (ex_alu_result[1:0]),
        .funct3_i     (ex_funct3),
        .mem_read_i   (ex_mem_read),
        .mem_write_i  (ex_mem_write),
        .store_data_i (ex_store_data),
        .rdata_i      (dmem_rdata),
        .wdata_o      (dmem_wdata),
        .be_o         (dmem_be),
        .load_data_o  (load_data),
        .bad_o        (bad)
    );

    assign is_mem  = ex_valid & (ex_mem_read | ex_mem_write);
    assign legal   = is_mem & ~bad;
    assign timeout = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT));

    // Once the wait budget is spent the request is withdrawn, so a late ready is ignored.
    assign dmem_req     = ~rst & legal & ~timeout;
    assign mem_stall    = dmem_req & ~dmem_ready;
    assign mem_misalign = ~rst & is_mem & bad & ~timeout;
    assign mem_fault    = ~rst & timeout;
    assign dmem_we      = ex_mem_write;
    assign dmem_addr    = {ex_alu_result[31:2], 2'b00};

    always_comb begin
        state_d = IDLE;
        cnt_d   = '0;
        if (mem_stall) begin
            state_d = WAIT;
            cnt_d   = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
        end
    end

    always_comb begin
        wb_d = '0;
        if (!mem_stall && ex_valid) begin
            wb_d.valid      = 1'b1;
            wb_d.alu_result = ex_alu_result;
            wb_d.mem_to_reg = ex_mem_to_reg;
            wb_d.rd         = ex_rd;
            // A faulting instruction retires without writing the register file.
            if (!(mem_misalign || mem_fault)) begin
                wb_d.reg_write = ex_reg_write;
                wb_d.mem_data  = ex_mem_read ? load_data : 32'h0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
        end
    end

    assign wb_valid      = wb_q.valid;
    assign wb_alu_result = wb_q.alu_result;
    assign wb_mem_data   = wb_q.mem_data;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_rd         = wb_q.rd;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RISC-V pipeline, between the EX/MEM register and the write-back stage. It formats loads and stores, drives the data-memory request/ready handshake, and stalls the front of the pipeline while memory waits. It holds the MEM/WB pipeline register, whose outputs feed write-back directly. Misaligned accesses and memory timeouts are reported, and the faulting instruction retires as a bubble.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles a request is held without `dmem_ready` before it faults; must be ≥ 2.

Ports (one clock, `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a real instruction
- ex_alu_result  in  32  ALU result / effective address
- ex_store_data  in  32  rs2 value for stores
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  access size/sign
- ex_mem_to_reg  in  1  pass-through
- ex_reg_write  in  1  pass-through
- ex_rd  in  5  destination register
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  access completes this cycle; `dmem_rdata` is valid in the same cycle
- dmem_rdata  in  32  read word
- mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- mem_misalign  out  1  one-cycle pulse: misaligned or illegal access
- mem_fault  out  1  one-cycle pulse: timeout
- wb_valid  out  1  MEM/WB valid
- wb_alu_result  out  32  registered
- wb_mem_data  out  32  registered, formatted load data
- wb_mem_to_reg  out  1  registered
- wb_reg_write  out  1  registered
- wb_rd  out  5  registered

## Operation
Memory operation:
- `is_mem = ex_valid & (ex_mem_read | ex_mem_write)`.
- Byte offset `off = ex_alu_result[1:0]`.

Illegal access (`bad`):
- Halfword access with `off[0]=1`.
- Word access with `off≠0`.
- Load funct3 ∈ {011, 110, 111}.
- Store funct3 > 010.
- Load and store both set.

When `is_mem & bad`:
- No request is issued.
- `mem_misalign=1` for that cycle.
- MEM/WB captures the instruction with `wb_reg_write=0`; `wb_valid=1`.

Store formatting:
- SB: byte replicated ×4, `be = 0001<<off`.
- SH: half replicated ×2, `be = 0011<<off`.
- SW: word as is, `be = 1111`.
- Loads drive `be = 1111`.

Load formatting from `dmem_rdata`, lane selected by `off`:
- LB / LH: sign-extend.
- LBU / LHU: zero-extend.
- LW: word as is.

FSM (`IDLE`, `WAIT`) with wait counter `cnt`, width `$clog2(TIMEOUT+1)`:
- IDLE, legal memory op: `dmem_req=1`.
  - If `dmem_ready`: complete and stay in IDLE.
  - Otherwise: `mem_stall=1`, MEM/WB loads a bubble, go to WAIT, `cnt=1`.
- IDLE, non-memory or bubble instruction: passes straight into MEM/WB; `mem_stall=0`.
- WAIT, `cnt<TIMEOUT`: `dmem_req=1`; upstream holds the EX/MEM inputs stable.
  - If `dmem_ready`: complete, go to IDLE, `mem_stall=0`.
  - Otherwise: `cnt++`, `mem_stall=1`, MEM/WB loads a bubble.
- WAIT, `cnt==TIMEOUT`:
  - `dmem_req=0`; `dmem_ready` is ignored.
  - `mem_fault=1`, `mem_stall=0`.
  - MEM/WB captures the instruction with `wb_reg_write=0`.
  - Go to IDLE.

Completion writes MEM/WB with all fields from EX/MEM inputs and formatted `wb_mem_data`. For stores and non-memory instructions, `wb_mem_data=0`.

A bubble is all-zero: `wb_valid=0`, `wb_reg_write=0`.

## Timing
- Zero-wait access: the instruction is presented in cycle 0, and MEM/WB updates at the end of cycle 0. Latency is 1 cycle, the same as a non-memory instruction.
- `dmem_ready` first seen in cycle k (1 ≤ k < TIMEOUT): `mem_stall` is high in cycles 0..k−1, and MEM/WB updates at the end of cycle k.
- A request is held for at most TIMEOUT cycles (cycles 0..TIMEOUT−1). The fault occurs in cycle TIMEOUT.
- `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_be` are combinational from the EX/MEM inputs. They stay stable while `dmem_req` is high, because upstream is stalled.
- `mem_stall`, `mem_misalign` and `mem_fault` are combinational and mutually exclusive in any cycle.
- `dmem_ready` while `dmem_req=0` is ignored.
- Reset, asynchronous:
  - state=IDLE, `cnt=0`.
  - All `wb_*` outputs = 0.
  - While `rst=1`, `dmem_req`, `mem_stall`, `mem_misalign` and `mem_fault` are forced to 0.
  - Reset during WAIT abandons the access; no write-back occurs.

## Structure
- Shared package `riscv_pkg` holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the `mem_state_t` enum {IDLE, WAIT}.
- Sub-module `lsu_align`, purely combinational:
  - store replication and byte enables;
  - load extraction and extension;
  - `bad` detection.
- `mem_stage` holds the FSM, the counter and the MEM/WB register.

## Test plan
- LW, `addr=0x104`, `rdata=0xDEADBEEF`, ready in cycle 0 → `wb_mem_data=0xDEADBEEF`, `wb_reg_write=1`, `mem_stall` never high.
- LB at `addr=0x103`, `rdata=0x80FF_0000`, then LBU at the same address → `wb_mem_data=0xFFFF_FF80`, then `0x0000_0080`.
- SH at `addr=0x202`, `data=0x1234ABCD`, ready after 3 wait cycles → `dmem_be=1100`, `dmem_wdata=0xABCDABCD`, `mem_stall` high for exactly 3 cycles, and 3 bubbles reach MEM/WB.
- LW at `addr=0x101` → `mem_misalign` pulses, `dmem_req` stays 0, `wb_reg_write=0`.
- TIMEOUT=4, `dmem_ready` held low → `dmem_req` high for 4 cycles, `mem_fault` pulses in cycle 4, `wb_reg_write=0`, and the next instruction proceeds.
- `rst` asserted during WAIT → `dmem_req` and `mem_stall` drop immediately, and all `wb_*` outputs = 0.
